debug_tx_scheduler: RTL and testbench
=====================================

DEBUG_TX_SCHEDULER -- requirements
Module: debug_tx_scheduler

Interface
REQ-001 Parameter: LOWER_HEX, default 0; 1 selects 'a'-'f' for hex digits 10-15, 0 selects 'A'-'F'.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 echo_valid  in  1  command parser has one byte to echo.
REQ-005 echo_data  in  8  byte to echo.
REQ-006 echo_ack  out  1  echo byte accepted this cycle (combinational).
REQ-007 idle_in  in  1  command parser idle; response records may only start while high.
REQ-008 rresp_empty  in  1  read-response FIFO empty.
REQ-009 rresp_data  in  39  read record: [38:32] id, [31:0] data.
REQ-010 rresp_pop  out  1  one-cycle pop of read-response FIFO.
REQ-011 bresp_empty  in  1  write-response FIFO empty.
REQ-012 bresp_bid  in  7  write-response id.
REQ-013 bresp_pop  out  1  one-cycle pop of write-response FIFO.
REQ-014 tx_fifo_full  in  1  UART TX FIFO cannot accept a byte.
REQ-015 tx_fifo_data  out  8  byte to TX FIFO.
REQ-016 tx_fifo_write  out  1  write strobe; never asserted while tx_fifo_full=1.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, RMSG, BMSG; 4-bit down-counter cnt; 39-bit record register rec; 1-bit round-robin pointer rr (0 = read next preferred).
REQ-019 IDLE, echo_valid=1, tx_fifo_full=0: tx_fifo_data=echo_data, tx_fifo_write=1, echo_ack=1; state unchanged; echo has priority over starting a record.
REQ-020 IDLE, no echo accepted, idle_in=1, one response FIFO non-empty: grant that source.
REQ-021 IDLE, both non-empty, idle_in=1: grant read if rr=0, else write.
REQ-022 Grant cycle: pulse the granted pop for exactly one cycle, latch rresp_data (or {32'b0,bresp_bid}) into rec, load cnt=13 (RMSG) or 4 (BMSG), move to state; no TX write in grant cycle.
REQ-023 RMSG emits 13 bytes in order: 'r', hex(rec[38:36]), hex(rec[35:32]), '.', hex nibbles rec[31:28] down to rec[3:0], 0x0A.
REQ-024 BMSG emits 4 bytes in order: 'b', hex(rec[6:4]), hex(rec[3:0]), 0x0A.
REQ-025 In RMSG/BMSG: one byte per cycle when tx_fifo_full=0; cnt decrements only on a write; tx_fifo_full=1 stalls with byte and cnt held.
REQ-026 Write of byte with cnt=1: return to IDLE next cycle, set rr=1 after RMSG, rr=0 after BMSG.
REQ-027 echo_ack=0 whenever state is not IDLE; messages are never interleaved with echo bytes.
REQ-028 hex(n): n<10 -> 0x30+n; else 0x41+n-10 (LOWER_HEX=0) or 0x61+n-10 (LOWER_HEX=1); 3-bit fields zero-extended.
REQ-029 tx_fifo_data=0 when tx_fifo_write=0.
REQ-030 idle_in dropping during RMSG/BMSG does not abort the message.
REQ-031 Back-to-back records: after return to IDLE, next grant no earlier than the following cycle; minimum record period = length+1 cycles.

Reset
REQ-032 rst_n=0: state=IDLE, cnt=0, rec=0, rr=0; echo_ack, rresp_pop, bresp_pop, tx_fifo_write, busy, tx_fifo_data all 0.
REQ-033 Reset mid-message aborts immediately; the already-popped record is discarded, not re-sent.

Verification
REQ-034 rresp_data={7'h25,32'hDEADBEEF}, idle_in=1, full=0 -> rresp_pop one cycle, then "r25.DEADBEEF\n" on 13 consecutive cycles, busy low after.
REQ-035 bresp_bid=7'h5C, LOWER_HEX=1 -> "b5c\n"; with LOWER_HEX=0 -> "b5C\n".
REQ-036 Both FIFOs non-empty continuously from reset -> read record, write record, read record, alternating.
REQ-037 tx_fifo_full=1 for 5 cycles after third byte of read message -> no write while full, byte 4 '.' held, total 18 write-window cycles, no byte lost or duplicated.
REQ-038 echo_valid=1 during BMSG -> echo_ack=0 until IDLE, then echo byte written next IDLE cycle ahead of pending rresp.
REQ-039 rst_n pulsed low at cnt=7 of RMSG -> all outputs 0 asynchronously; after release no residual bytes, next non-empty FIFO granted normally.

Source files
------------

// File: rtl/debug_tx_if.sv
// Handshake bundle between the command parser, the response FIFOs, the UART TX FIFO
// and the debug TX scheduler. The slave modport is the scheduler's view.
interface debug_tx_if;
  logic        echo_valid;
  logic [7:0]  echo_data;
  logic        echo_ack;
  logic        idle_in;
  logic        rresp_empty;
  logic [38:0] rresp_data;
  logic        rresp_pop;
  logic        bresp_empty;
  logic [6:0]  bresp_bid;
  logic        bresp_pop;
  logic        tx_fifo_full;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_write;
  logic        busy;

  modport master (
    output echo_valid, echo_data, idle_in, rresp_empty, rresp_data,
           bresp_empty, bresp_bid, tx_fifo_full,
    input  echo_ack, rresp_pop, bresp_pop, tx_fifo_data, tx_fifo_write, busy
  );

  modport slave (
    input  echo_valid, echo_data, idle_in, rresp_empty, rresp_data,
           bresp_empty, bresp_bid, tx_fifo_full,
    output echo_ack, rresp_pop, bresp_pop, tx_fifo_data, tx_fifo_write, busy
  );
endinterface

// File: rtl/debug_tx_scheduler.sv
// Serialises echo bytes and read/write response records as ASCII text into the UART TX FIFO.
// Read record: "rII.DDDDDDDD\n", write record: "bII\n"; echo bytes pass through while idle.
module debug_tx_scheduler #(
  parameter bit LOWER_HEX = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  debug_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RMSG, BMSG} state_e;

  state_e      state, state_nxt;
  logic [3:0]  cnt;
  logic [38:0] rec;
  logic        rr;

  logic        echo_go, grant_r, grant_b, byte_wr;
  logic [7:0]  msg_byte;
  logic [31:0] nib_sh;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (LOWER_HEX ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  // Arbitration in IDLE: echo first, then round-robin between the two response FIFOs.
  always_comb begin
    echo_go = 1'b0;
    grant_r = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (bus.echo_valid && !bus.tx_fifo_full) echo_go = 1'b1;
      else if (bus.idle_in) begin
        if (!bus.rresp_empty && (!rr || bus.bresp_empty)) grant_r = 1'b1;
        else if (!bus.bresp_empty)                         grant_b = 1'b1;
      end
    end
  end

  assign byte_wr = (state != IDLE) && !bus.tx_fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (grant_r) state_nxt = RMSG;
                  else if (grant_b) state_nxt = BMSG;
      RMSG, BMSG: if (byte_wr && cnt == 4'd1) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // cnt counts the bytes still to send; the last byte is always the newline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      rec <= 39'd0;
      rr  <= 1'b0;
    end else if (grant_r) begin
      rec <= bus.rresp_data;
      cnt <= 4'd13;
    end else if (grant_b) begin
      rec <= {32'd0, bus.bresp_bid};
      cnt <= 4'd4;
    end else if (byte_wr) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) rr <= (state == RMSG);
    end
  end

  // Data nibbles go out MSB first: cnt 9 selects rec[31:28], cnt 2 selects rec[3:0].
  assign nib_sh = rec[31:0] >> {cnt - 4'd2, 2'b00};

  always_comb begin
    msg_byte = 8'h0A;
    if (state == RMSG) begin
      case (cnt)
        4'd13:   msg_byte = 8'h72;
        4'd12:   msg_byte = hex({1'b0, rec[38:36]});
        4'd11:   msg_byte = hex(rec[35:32]);
        4'd10:   msg_byte = 8'h2E;
        4'd1:    msg_byte = 8'h0A;
        default: msg_byte = hex(nib_sh[3:0]);
      endcase
    end else if (state == BMSG) begin
      case (cnt)
        4'd4:    msg_byte = 8'h62;
        4'd3:    msg_byte = hex({1'b0, rec[6:4]});
        4'd2:    msg_byte = hex(rec[3:0]);
        default: msg_byte = 8'h0A;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    bus.echo_ack      = 1'b0;
    bus.rresp_pop     = 1'b0;
    bus.bresp_pop     = 1'b0;
    bus.busy          = 1'b0;
    bus.tx_fifo_write = 1'b0;
    bus.tx_fifo_data  = 8'h00;
    if (rst_n) begin
      bus.echo_ack      = echo_go;
      bus.rresp_pop     = grant_r;
      bus.bresp_pop     = grant_b;
      bus.busy          = (state != IDLE);
      bus.tx_fifo_write = echo_go | byte_wr;
      if (echo_go)      bus.tx_fifo_data = bus.echo_data;
      else if (byte_wr) bus.tx_fifo_data = msg_byte;
    end
  end
endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Drives two schedulers (upper/lower-case hex) with identical stimulus and checks them
// against a byte-queue model built from formatted strings.
module tb_debug_tx_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        echo_valid, idle_in, tx_fifo_full, rresp_empty, bresp_empty;
  logic [7:0]  echo_data;
  logic [38:0] rresp_data;
  logic [6:0]  bresp_bid;

  debug_tx_if bus_up ();
  debug_tx_if bus_lo ();

  assign bus_up.echo_valid   = echo_valid;   assign bus_lo.echo_valid   = echo_valid;
  assign bus_up.echo_data    = echo_data;    assign bus_lo.echo_data    = echo_data;
  assign bus_up.idle_in      = idle_in;      assign bus_lo.idle_in      = idle_in;
  assign bus_up.tx_fifo_full = tx_fifo_full; assign bus_lo.tx_fifo_full = tx_fifo_full;
  assign bus_up.rresp_empty  = rresp_empty;  assign bus_lo.rresp_empty  = rresp_empty;
  assign bus_up.rresp_data   = rresp_data;   assign bus_lo.rresp_data   = rresp_data;
  assign bus_up.bresp_empty  = bresp_empty;  assign bus_lo.bresp_empty  = bresp_empty;
  assign bus_up.bresp_bid    = bresp_bid;    assign bus_lo.bresp_bid    = bresp_bid;

  debug_tx_scheduler #(.LOWER_HEX(1'b0)) dut_up (.clk(clk), .rst_n(rst_n), .bus(bus_up));
  debug_tx_scheduler #(.LOWER_HEX(1'b1)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(bus_lo));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_first = 0, wr_last = 0;

  // Reference state: pending FIFO contents, bytes still owed, round-robin preference.
  logic [38:0] rq[$];
  logic [6:0]  bq[$];
  logic [7:0]  msg_u[$], msg_l[$];
  logic [7:0]  log_u[$], log_l[$];
  bit          glog[$];
  bit          m_rr = 1'b0;
  bit          cur_rd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {bus_up.echo_ack, bus_up.rresp_pop, bus_up.bresp_pop, bus_up.tx_fifo_write,
                        bus_up.busy, bus_lo.echo_ack, bus_lo.rresp_pop, bus_lo.bresp_pop,
                        bus_lo.tx_fifo_write, bus_lo.busy}, 64'd0);
    chk({tag, "_dat"}, {bus_up.tx_fifo_data, bus_lo.tx_fifo_data}, 64'd0);
  endtask

  function automatic void load_msg(input bit rd, input logic [38:0] r, input logic [6:0] b);
    string h, su, sl;
    if (rd) begin
      h  = $sformatf("%02h.%08h", r[38:32], r[31:0]);
      sl = {"r", h, "\n"};
      su = {"r", h.toupper(), "\n"};
    end else begin
      h  = $sformatf("%02h", b);
      sl = {"b", h, "\n"};
      su = {"b", h.toupper(), "\n"};
    end
    for (int i = 0; i < su.len(); i++) begin
      msg_u.push_back(su[i]);
      msg_l.push_back(sl[i]);
    end
  endfunction

  task automatic step(input bit ev, input logic [7:0] ed, input bit idl, input bit full);
    bit e_ack, e_rp, e_bp, e_wr, e_busy;
    logic [7:0] e_du, e_dl;
    @(negedge clk);
    cyc++;
    echo_valid   = ev;
    echo_data    = ed;
    idle_in      = idl;
    tx_fifo_full = full;
    rresp_empty  = (rq.size() == 0);
    rresp_data   = (rq.size() != 0) ? rq[0] : 39'd0;
    bresp_empty  = (bq.size() == 0);
    bresp_bid    = (bq.size() != 0) ? bq[0] : 7'd0;
    #1;
    {e_ack, e_rp, e_bp, e_wr} = '0;
    e_du = 8'h00;
    e_dl = 8'h00;
    e_busy = (msg_u.size() != 0);
    if (e_busy) begin
      if (!full) begin
        e_wr = 1'b1; e_du = msg_u[0]; e_dl = msg_l[0];
      end
    end else if (ev && !full) begin
      e_ack = 1'b1; e_wr = 1'b1; e_du = ed; e_dl = ed;
    end else if (idl && (rq.size() != 0 || bq.size() != 0)) begin
      if (rq.size() != 0 && (!m_rr || bq.size() == 0)) e_rp = 1'b1;
      else                                             e_bp = 1'b1;
    end
    chk("ack",  {bus_up.echo_ack,      bus_lo.echo_ack},      {e_ack, e_ack});
    chk("rpop", {bus_up.rresp_pop,     bus_lo.rresp_pop},     {e_rp, e_rp});
    chk("bpop", {bus_up.bresp_pop,     bus_lo.bresp_pop},     {e_bp, e_bp});
    chk("wr",   {bus_up.tx_fifo_write, bus_lo.tx_fifo_write}, {e_wr, e_wr});
    chk("busy", {bus_up.busy,          bus_lo.busy},          {e_busy, e_busy});
    chk("data", {bus_up.tx_fifo_data,  bus_lo.tx_fifo_data},  {e_du, e_dl});
    if (bus_up.tx_fifo_write) begin
      if (log_u.size() == 0) wr_first = cyc;
      wr_last = cyc;
      log_u.push_back(bus_up.tx_fifo_data);
      log_l.push_back(bus_lo.tx_fifo_data);
    end
    // Advance the model to the state after the coming rising edge.
    if (e_busy && !full) begin
      void'(msg_u.pop_front());
      void'(msg_l.pop_front());
      if (msg_u.size() == 0) m_rr = cur_rd;
    end else if (e_rp) begin
      cur_rd = 1'b1; glog.push_back(1'b1);
      load_msg(1'b1, rq.pop_front(), 7'd0);
    end else if (e_bp) begin
      cur_rd = 1'b0; glog.push_back(1'b0);
      load_msg(1'b0, 39'd0, bq.pop_front());
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    echo_valid = 1'b1;
    idle_in = 1'b1;
    #1 chk_zero(tag);
    echo_valid = 1'b0;
    idle_in = 1'b0;
    msg_u.delete(); msg_l.delete();
    m_rr = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic clr_log();
    log_u.delete(); log_l.delete(); glog.delete();
  endtask

  task automatic cmp_log(input string tag, input string su, input string sl);
    chk({tag, "_len"}, log_u.size(), su.len());
    for (int i = 0; i < su.len(); i++)
      chk(tag, {(i < log_u.size()) ? log_u[i] : 8'h00, (i < log_l.size()) ? log_l[i] : 8'h00},
               {su[i], sl[i]});
  endtask

  initial begin
    echo_valid = 1'b1; echo_data = 8'h41; idle_in = 1'b1; tx_fifo_full = 1'b0;
    rresp_empty = 1'b0; rresp_data = 39'h1_2345_6789; bresp_empty = 1'b0; bresp_bid = 7'h12;
    #3 chk_zero("por");
    echo_valid = 1'b0; idle_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Single read record
    clr_log();
    rq.push_back({7'h25, 32'hDEADBEEF});
    quiet(16);
    cmp_log("rd_msg", "r25.DEADBEEF\n", "r25.deadbeef\n");

    // Single write record, both hex cases
    clr_log();
    bq.push_back(7'h5C);
    quiet(6);
    cmp_log("wr_msg", "b5C\n", "b5c\n");

    // Both sources pending from reset: strict alternation starting with read
    do_reset("rst1");
    clr_log();
    for (int i = 0; i < 3; i++) begin
      rq.push_back({7'(i + 1), 32'h1000_0000 * (i + 1)});
      bq.push_back(7'(7'h40 + i));
    end
    quiet(62);
    chk("rr_len", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_order", glog[i], (i % 2) == 0);

    // Back-pressure after the third read byte
    clr_log();
    rq.push_back({7'h7A, 32'h0BAD_F00D});
    quiet(4);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    quiet(11);
    cmp_log("stall", "r7A.0BADF00D\n", "r7a.0badf00d\n");
    chk("stall_win", wr_last - wr_first + 1, 18);

    // Echo held off during a write record, then wins over a pending read
    clr_log();
    bq.push_back(7'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    rq.push_back({7'h03, 32'h1234_5678});
    for (int i = 0; i < 5; i++) step(1'b1, 8'h7E, 1'b0, 1'b0);
    quiet(15);
    cmp_log("echo", "b11\n~r03.12345678\n", "b11\n~r03.12345678\n");

    // Reset mid read record, cnt=7
    clr_log();
    rq.push_back({7'h44, 32'hCAFE_F00D});
    quiet(7);
    do_reset("rst_mid");
    chk("mid_bytes", log_u.size(), 6);
    clr_log();
    bq.push_back(7'h7F);
    quiet(7);
    cmp_log("post_rst", "b7F\n", "b7f\n");

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if (rq.size() < 3 && $urandom_range(0, 9) == 0) rq.push_back({7'($urandom), 32'($urandom)});
      if (bq.size() < 3 && $urandom_range(0, 7) == 0) bq.push_back(7'($urandom));
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
